// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler: keypad authentication with lockout, request
// latching while authorised, and SCAN-ordered target issue to the controller.
module elevator_request_scheduler #(
    parameter logic [3:0] PASSWORD       = 4'b1010,
    parameter int         MAX_ATTEMPTS   = 3,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_btn,
    input  logic [3:0] key_digit,
    input  logic       key_valid,
    input  logic [1:0] current_floor,
    input  logic       door_open,
    output logic [1:0] floor_select,
    output logic [3:0] password,
    output logic       req_valid,
    output logic [3:0] pending,
    output logic       auth_ok,
    output logic       locked
);

    typedef enum logic [1:0] {
        AUTH_WAIT  = 2'd0,
        AUTHORIZED = 2'd1,
        LOCKOUT    = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [2:0] fail_cnt, fail_cnt_next;
    logic [7:0] lock_cnt, lock_cnt_next;
    logic       dir_up, dir_up_next;
    logic       done_q, done_next;
    logic [3:0] pending_next;
    logic [1:0] floor_select_next;
    logic       req_valid_next;
    logic       retire;
    logic [3:0] retire_mask;
    logic       select_en;
    logic [2:0] up_hit, dn_hit, low_any, high_any;

    // {found, floor}: lowest pending floor at or above the given floor
    function automatic logic [2:0] lowest_at_or_above(input logic [3:0] pend,
                                                      input logic [1:0] floor);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i] && (i >= int'(floor))) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    // {found, floor}: highest pending floor at or below the given floor
    function automatic logic [2:0] highest_at_or_below(input logic [3:0] pend,
                                                       input logic [1:0] floor);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 0; i <= 3; i++) begin
            if (pend[i] && (i <= int'(floor))) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign auth_ok  = (state == AUTHORIZED);
    assign locked   = (state == LOCKOUT);
    assign password = auth_ok ? PASSWORD : 4'b0000;

    // Retire, request latching and SCAN target selection
    always_comb begin
        retire       = req_valid && (current_floor == floor_select) && door_open;
        retire_mask  = retire ? (4'b0001 << floor_select) : 4'b0000;
        // A clear of the retiring floor overrides a simultaneous press of it
        pending_next = (pending | (auth_ok ? req_btn : 4'b0000)) & ~retire_mask;
        done_next    = retire && (pending_next == 4'b0000);
        select_en    = auth_ok && !req_valid && (pending != 4'b0000);
        up_hit       = lowest_at_or_above(pending, current_floor);
        dn_hit       = highest_at_or_below(pending, current_floor);
        low_any      = lowest_at_or_above(pending, 2'd0);
        high_any     = highest_at_or_below(pending, 2'd3);

        floor_select_next = floor_select;
        req_valid_next    = req_valid;
        dir_up_next       = dir_up;
        if (retire) begin
            req_valid_next = 1'b0;
        end else if (select_en) begin
            req_valid_next = 1'b1;
            if (dir_up) begin
                if (up_hit[2]) begin
                    floor_select_next = up_hit[1:0];
                end else begin
                    floor_select_next = high_any[1:0];
                    dir_up_next       = 1'b0;
                end
            end else begin
                if (dn_hit[2]) begin
                    floor_select_next = dn_hit[1:0];
                end else begin
                    floor_select_next = low_any[1:0];
                    dir_up_next       = 1'b1;
                end
            end
        end
    end

    // Auth FSM next state, failure counter and lockout timer
    always_comb begin
        state_next    = state;
        fail_cnt_next = fail_cnt;
        lock_cnt_next = lock_cnt;
        case (state)
            AUTH_WAIT: begin
                if (key_valid) begin
                    if (key_digit == PASSWORD) begin
                        state_next    = AUTHORIZED;
                        fail_cnt_next = 3'd0;
                    end else begin
                        fail_cnt_next = fail_cnt + 3'd1;
                        if ((fail_cnt + 3'd1) == 3'(MAX_ATTEMPTS)) begin
                            state_next    = LOCKOUT;
                            lock_cnt_next = 8'(LOCKOUT_CYCLES);
                        end
                    end
                end
            end
            LOCKOUT: begin
                // Exit on the edge that takes the timer to zero so that
                // locked stays high for exactly LOCKOUT_CYCLES cycles
                if (lock_cnt <= 8'd1) begin
                    state_next    = AUTH_WAIT;
                    lock_cnt_next = 8'd0;
                    fail_cnt_next = 3'd0;
                end else begin
                    lock_cnt_next = lock_cnt - 8'd1;
                end
            end
            AUTHORIZED: begin
                // Session ends the cycle after the last request retires,
                // unless a new press arrives in that cycle
                if (done_q && (pending == 4'b0000) && (req_btn == 4'b0000)) begin
                    state_next = AUTH_WAIT;
                end
            end
            default: state_next = AUTH_WAIT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= AUTH_WAIT;
        else      state <= state_next;
    end

    // Counters, request vector, direction and issued target
    always_ff @(posedge clk) begin
        if (!rst) begin
            fail_cnt     <= 3'd0;
            lock_cnt     <= 8'd0;
            pending      <= 4'b0000;
            floor_select <= 2'd0;
            req_valid    <= 1'b0;
            dir_up       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            fail_cnt     <= fail_cnt_next;
            lock_cnt     <= lock_cnt_next;
            pending      <= pending_next;
            floor_select <= floor_select_next;
            req_valid    <= req_valid_next;
            dir_up       <= dir_up_next;
            done_q       <= done_next;
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed testbench for elevator_request_scheduler.
module tb_elevator_request_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req_btn;
    logic [3:0] key_digit;
    logic       key_valid;
    logic [1:0] current_floor;
    logic       door_open;
    logic [1:0] floor_select;
    logic [3:0] password;
    logic       req_valid;
    logic [3:0] pending;
    logic       auth_ok;
    logic       locked;

    int checks = 0;
    int errors = 0;

    elevator_request_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req_btn      (req_btn),
        .key_digit    (key_digit),
        .key_valid    (key_valid),
        .current_floor(current_floor),
        .door_open    (door_open),
        .floor_select (floor_select),
        .password     (password),
        .req_valid    (req_valid),
        .pending      (pending),
        .auth_ok      (auth_ok),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req_btn = 4'b0; key_digit = 4'b0; key_valid = 1'b0;
        current_floor = 2'd0; door_open = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic enter_code(input logic [3:0] code);
        key_digit = code; key_valid = 1'b1;
        tick();
        key_valid = 1'b0; key_digit = 4'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (floor_select !== 2'd0) begin errors++; $display("FAIL reset_floor_select: got %0d expected 0", floor_select); end
        checks++; if (password !== 4'b0000) begin errors++; $display("FAIL reset_password: got %b expected 0000", password); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++; if (auth_ok !== 1'b0) begin errors++; $display("FAIL reset_auth_ok: got %b expected 0", auth_ok); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    endtask

    task automatic test_basic();
        do_reset();
        current_floor = 2'd0;
        enter_code(4'b1010);
        checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL basic_auth_ok: got %b expected 1", auth_ok); end
        checks++; if (password !== 4'b1010) begin errors++; $display("FAIL basic_password: got %b expected 1010", password); end
        req_btn = 4'b0010;
        tick();
        req_btn = 4'b0000;
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL basic_pending_latch: got %b expected 0010", pending); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL basic_req_valid_early: got %b expected 0", req_valid); end
        tick();
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL basic_req_valid: got %b expected 1", req_valid); end
        checks++; if (floor_select !== 2'd1) begin errors++; $display("FAIL basic_floor_select: got %0d expected 1", floor_select); end
        current_floor = 2'd1; door_open = 1'b1;
        tick();
        door_open = 1'b0;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL basic_retire_pending: got %b expected 0000", pending); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL basic_retire_req_valid: got %b expected 0", req_valid); end
        checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL basic_auth_hold: got %b expected 1", auth_ok); end
        tick();
        checks++; if (auth_ok !== 1'b0) begin errors++; $display("FAIL basic_auth_drop: got %b expected 0", auth_ok); end
        checks++; if (password !== 4'b0000) begin errors++; $display("FAIL basic_password_drop: got %b expected 0000", password); end
    endtask

    task automatic test_lockout();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick();
            enter_code(4'b0001);
            checks++;
            if (locked !== (k == 3)) begin
                errors++; $display("FAIL lockout_attempt%0d: got %b expected %b", k, locked, (k == 3));
            end
        end
        for (int c = 2; c <= 16; c++) begin
            if (c == 4) enter_code(4'b1010);
            else tick();
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lockout_cycle%0d: got %b expected 1", c, locked); end
        end
        tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lockout_release: got %b expected 0", locked); end
        checks++; if (auth_ok !== 1'b0) begin errors++; $display("FAIL lockout_code_ignored: got %b expected 0", auth_ok); end
        enter_code(4'b1010);
        checks++; if (auth_ok !== 1'b1) begin errors++; $display("FAIL lockout_after_auth: got %b expected 1", auth_ok); end
    endtask

    task automatic test_scan();
        do_reset();
        current_floor = 2'd1;
        enter_code(4'b1010);
        req_btn = 4'b1001;
        tick();
        req_btn = 4'b0000;
        checks++; if (pending !== 4'b1001) begin errors++; $display("FAIL scan_pending: got %b expected 1001", pending); end
        tick();
        checks++; if (req_valid !== 1'b1 || floor_select !== 2'd3) begin errors++; $display("FAIL scan_first: got v=%b f=%0d expected v=1 f=3", req_valid, floor_select); end
        current_floor = 2'd3; door_open = 1'b1;
        tick();
        door_open = 1'b0;
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL scan_retire3: got %b expected 0001", pending); end
        tick();
        checks++; if (req_valid !== 1'b1 || floor_select !== 2'd0) begin errors++; $display("FAIL scan_reverse: got v=%b f=%0d expected v=1 f=0", req_valid, floor_select); end
        current_floor = 2'd0; door_open = 1'b1;
        tick();
        door_open = 1'b0;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL scan_retire0: got %b expected 0000", pending); end
    endtask

    task automatic test_same_cycle_clear();
        do_reset();
        current_floor = 2'd0;
        enter_code(4'b1010);
        req_btn = 4'b0100;
        tick();
        req_btn = 4'b0000;
        tick();
        checks++; if (req_valid !== 1'b1 || floor_select !== 2'd2) begin errors++; $display("FAIL clear_target: got v=%b f=%0d expected v=1 f=2", req_valid, floor_select); end
        req_btn = 4'b0010;
        tick();
        req_btn = 4'b0000;
        checks++; if (pending !== 4'b0110 || floor_select !== 2'd2) begin errors++; $display("FAIL clear_hold: got p=%b f=%0d expected p=0110 f=2", pending, floor_select); end
        current_floor = 2'd2; door_open = 1'b1; req_btn = 4'b0100;
        tick();
        door_open = 1'b0; req_btn = 4'b0000;
        checks++; if (pending !== 4'b0010 || req_valid !== 1'b0) begin errors++; $display("FAIL clear_wins: got p=%b v=%b expected p=0010 v=0", pending, req_valid); end
        tick();
        checks++; if (req_valid !== 1'b1 || floor_select !== 2'd1) begin errors++; $display("FAIL clear_no_reissue: got v=%b f=%0d expected v=1 f=1", req_valid, floor_select); end
    endtask

    task automatic test_auth_wait_ignore();
        do_reset();
        req_btn = 4'b1111;
        tick();
        tick();
        req_btn = 4'b0000;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ignore_pending: got %b expected 0000", pending); end
        checks++; if (password !== 4'b0000) begin errors++; $display("FAIL ignore_password: got %b expected 0000", password); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL ignore_req_valid: got %b expected 0", req_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        current_floor = 2'd0;
        enter_code(4'b1010);
        req_btn = 4'b1010;
        tick();
        req_btn = 4'b0000;
        tick();
        checks++; if (req_valid !== 1'b1 || pending !== 4'b1010 || floor_select !== 2'd1) begin errors++; $display("FAIL mid_setup: got v=%b p=%b f=%0d expected v=1 p=1010 f=1", req_valid, pending, floor_select); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++; if ({floor_select, password, req_valid, pending, auth_ok, locked} !== 13'd0) begin
            errors++; $display("FAIL mid_reset_outputs: got f=%0d pw=%b v=%b p=%b a=%b l=%b expected all 0", floor_select, password, req_valid, pending, auth_ok, locked);
        end
        req_btn = 4'b0010;
        tick();
        req_btn = 4'b0000;
        checks++; if (pending !== 4'b0000 || auth_ok !== 1'b0) begin errors++; $display("FAIL mid_auth_wait: got p=%b a=%b expected p=0000 a=0", pending, auth_ok); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lockout();
        test_scan();
        test_same_cycle_clear();
        test_auth_wait_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
